// File: rtl/fir_mac_serial_if.sv
// fir_mac_serial_if
// Purpose: bundles the sample handshake, coefficient write port and result
// signals of fir_mac_serial. The master modport belongs to the side that
// feeds samples and coefficients. The slave modport belongs to the filter.
// Signals (direction given from master to slave unless noted):
//   clear       synchronous flush of delay line and pointer
//   in_valid    sample offered
//   in_ready    (slave->master) filter can accept a sample
//   x_in        signed input sample, DW bits
//   coef_we     coefficient write strobe
//   coef_addr   tap index, $clog2(N_TAPS) bits
//   coef_wdata  signed coefficient, CW bits
//   coef_rej    (slave->master) one-cycle pulse, write was rejected
//   y_valid     (slave->master) one-cycle pulse, y_out updated
//   y_out       (slave->master) signed filter output, OW bits, held
//   sat         (slave->master) y_out was clipped
interface fir_mac_serial_if #(
    parameter int N_TAPS = 63,
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int OW     = 32
) ();
    localparam int PW = $clog2(N_TAPS);

    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x_in;
    logic                 coef_we;
    logic [PW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 coef_rej;
    logic                 y_valid;
    logic signed [OW-1:0] y_out;
    logic                 sat;

    modport master (
        output clear, in_valid, x_in, coef_we, coef_addr, coef_wdata,
        input  in_ready, coef_rej, y_valid, y_out, sat
    );

    modport slave (
        input  clear, in_valid, x_in, coef_we, coef_addr, coef_wdata,
        output in_ready, coef_rej, y_valid, y_out, sat
    );
endinterface

// File: rtl/fir_mac_serial.sv
// fir_mac_serial
// Purpose: time-multiplexed FIR filter. One shared multiply-accumulate walks
// the N_TAPS taps of a circular delay line, one tap per clock. Coefficients
// are written at run time. The result is shifted right arithmetically by
// SHIFT, saturated to OW bits and flagged when it was clipped.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   fir_mac_serial_if.slave: sample handshake (in_valid/in_ready/x_in),
//         clear, coefficient port (coef_we/coef_addr/coef_wdata/coef_rej),
//         result (y_valid/y_out/sat)
module fir_mac_serial #(
    parameter int N_TAPS = 63,
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int OW     = 32,
    parameter int SHIFT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    fir_mac_serial_if.slave bus
);
    localparam int PW  = $clog2(N_TAPS);
    localparam int AW  = DW + CW + $clog2(N_TAPS);
    localparam int PRW = DW + CW;
    localparam logic [PW-1:0] LAST = PW'(N_TAPS - 1);
    localparam bit CAN_CLIP = (AW - SHIFT) > OW;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0]  samples [N_TAPS];
    logic signed [CW-1:0]  coefs   [N_TAPS];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         next_ptr;
    logic [PW-1:0]         k;
    logic [PW-1:0]         tap_idx;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  shifted;
    logic signed [PRW-1:0] product;
    logic signed [OW-1:0]  y_q;
    logic signed [OW-1:0]  y_next;
    logic                  sat_q;
    logic                  sat_next;
    logic                  y_valid_q;
    logic                  coef_rej_q;
    logic                  coef_ok;
    logic                  in_ready_c;

    // Pointer arithmetic stays in PW bits. When wr_ptr < k the true index
    // wr_ptr + N_TAPS - k lies in [0, N_TAPS), so wrapping modulo 2^PW in
    // the intermediate sum still gives the correct result.
    always_comb begin
        next_ptr = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        tap_idx  = (wr_ptr >= k) ? (wr_ptr - k) : (wr_ptr + (LAST - k) + PW'(1));
        product  = PRW'(coefs[k]) * PRW'(samples[tap_idx]);
        shifted  = acc >>> SHIFT;
        coef_ok  = (state_q == IDLE) && ({1'b0, bus.coef_addr} < (PW+1)'(N_TAPS));
    end

    // Saturation. When the shifted accumulator cannot exceed OW bits, it is
    // passed through (sign-extended if needed) and sat stays low.
    generate
        if (CAN_CLIP) begin : g_clip
            // The value fits only if every bit above OW-1 copies the sign.
            always_comb begin
                y_next   = shifted[OW-1:0];
                sat_next = 1'b0;
                if (!shifted[AW-1] && (|shifted[AW-2:OW-1])) begin
                    y_next   = {1'b0, {(OW-1){1'b1}}};
                    sat_next = 1'b1;
                end else if (shifted[AW-1] && !(&shifted[AW-2:OW-1])) begin
                    y_next   = {1'b1, {(OW-1){1'b0}}};
                    sat_next = 1'b1;
                end
            end
        end else begin : g_fit
            assign y_next   = OW'(shifted);
            assign sat_next = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. clear overrides everything and drops any sample
    // offered in the same cycle.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (k == LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.clear) begin
            state_d = IDLE;
        end
    end

    // Delay line, accumulator and result registers. y_out and sat survive a
    // clear so the downstream stage keeps its last valid value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                samples[i] <= '0;
            end
            wr_ptr    <= '0;
            acc       <= '0;
            k         <= '0;
            y_q       <= '0;
            sat_q     <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (bus.clear) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    samples[i] <= '0;
                end
                wr_ptr <= '0;
                acc    <= '0;
                k      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.in_valid) begin
                            samples[next_ptr] <= bus.x_in;
                            wr_ptr            <= next_ptr;
                            acc               <= '0;
                            k                 <= '0;
                        end
                    end
                    MAC: begin
                        acc <= acc + AW'(product);
                        k   <= k + PW'(1);
                    end
                    OUT: begin
                        y_q       <= y_next;
                        sat_q     <= sat_next;
                        y_valid_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Coefficient bank. Writes land only while idle, so a sample accepted in
    // the same cycle already sees the new value on its first MAC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coefs[i] <= '0;
            end
            coef_rej_q <= 1'b0;
        end else begin
            coef_rej_q <= 1'b0;
            if (bus.coef_we) begin
                if (coef_ok) begin
                    coefs[bus.coef_addr] <= bus.coef_wdata;
                end else begin
                    coef_rej_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.coef_rej = coef_rej_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.y_out    = y_q;
    assign bus.sat      = sat_q;
endmodule

// File: tb/tb_fir_mac_serial.sv
// tb_fir_mac_serial
// Purpose: directed self-checking bench for fir_mac_serial. The main
// instance has 8 taps and a 32-bit output. A 6-tap instance covers
// out-of-range coefficient addresses, which a 3-bit address can express.
module tb_fir_mac_serial;
    localparam int N_TAPS  = 8;
    localparam int N_SMALL = 6;
    localparam int DW      = 16;
    localparam int CW      = 16;
    localparam int OW      = 32;
    localparam int PW      = $clog2(N_TAPS);
    localparam longint Y_MAX = 64'sd2147483647;
    localparam longint Y_MIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   num_checks = 0;
    int   num_errors = 0;

    fir_mac_serial_if #(.N_TAPS(N_TAPS), .DW(DW), .CW(CW), .OW(OW)) bus ();
    fir_mac_serial_if #(.N_TAPS(N_SMALL), .DW(DW), .CW(CW), .OW(OW)) bus_small ();

    fir_mac_serial #(.N_TAPS(N_TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fir_mac_serial #(.N_TAPS(N_SMALL), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_small)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net in case a wait is ever left unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the write seen.
    task automatic writeCoef(input int addr, input int data, output logic rej);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = PW'(addr);
        bus.coef_wdata = CW'(data);
        @(negedge clk);
        bus.coef_we = 1'b0;
        rej = bus.coef_rej;
    endtask

    // Waits (bounded) for y_valid, counting cycles and cycles with in_ready low.
    task automatic waitOutput(output logic signed [OW-1:0] y, output logic s,
                              output int cycles, output int low);
        cycles = 0;
        low    = 0;
        while (!bus.y_valid && cycles < 50) begin
            if (!bus.in_ready) low++;
            @(negedge clk);
            cycles++;
        end
        y = bus.y_out;
        s = bus.sat;
    endtask

    // Offers one sample at a negedge and waits for its result.
    task automatic applyStimulus(input int x, output logic signed [OW-1:0] y, output logic s,
                                 output int latency, output int low);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.x_in     = DW'(x);
        @(negedge clk);
        bus.in_valid = 1'b0;
        waitOutput(y, s, latency, low);
    endtask

    task automatic feedAndCheck(input string tag, input int x, input longint exp_y,
                                input logic exp_sat, input bit check_ready);
        logic signed [OW-1:0] y;
        logic s;
        int lat;
        int low;
        applyStimulus(x, y, s, lat, low);
        checkOutput({tag, "_y"}, y, exp_y);
        checkOutput({tag, "_sat"}, s, exp_sat);
        checkOutput({tag, "_latency"}, lat, N_TAPS + 1);
        if (check_ready) begin
            checkOutput({tag, "_ready_low"}, low, N_TAPS + 1);
            checkOutput({tag, "_ready_back"}, bus.in_ready, 1);
        end
    endtask

    task automatic pulseClear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    initial begin
        logic rej;
        logic signed [OW-1:0] y;
        logic s;
        int lat;
        int low;
        int seen;
        longint neg_y [8];
        logic neg_sat [8];

        bus.clear = 1'b0;       bus.in_valid = 1'b0;   bus.x_in = '0;
        bus.coef_we = 1'b0;     bus.coef_addr = '0;    bus.coef_wdata = '0;
        bus_small.clear = 1'b0; bus_small.in_valid = 1'b0; bus_small.x_in = '0;
        bus_small.coef_we = 1'b0; bus_small.coef_addr = '0; bus_small.coef_wdata = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_y_out", bus.y_out, 0);
        checkOutput("reset_sat", bus.sat, 0);
        checkOutput("reset_y_valid", bus.y_valid, 0);
        checkOutput("reset_coef_rej", bus.coef_rej, 0);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Impulse response with coef[k] = k+1.
        for (int i = 0; i < N_TAPS; i++) begin
            writeCoef(i, i + 1, rej);
            checkOutput($sformatf("load_rej_%0d", i), rej, 0);
        end
        for (int i = 0; i < N_TAPS; i++) begin
            feedAndCheck($sformatf("impulse_%0d", i), (i == 0) ? 1 : 0, i + 1, 1'b0, 1'b1);
        end
        @(negedge clk);
        checkOutput("y_valid_one_cycle", bus.y_valid, 0);
        checkOutput("y_out_held", bus.y_out, 8);

        // Coefficient write during MAC is rejected and has no effect.
        pulseClear();
        bus.in_valid = 1'b1;
        bus.x_in     = 16'sd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        writeCoef(1, 50, rej);
        checkOutput("rej_in_mac", rej, 1);
        waitOutput(y, s, lat, low);
        checkOutput("rej_mac_latency", lat, N_TAPS);
        checkOutput("rej_mac_y", y, 1);
        feedAndCheck("rej_old_coef", 0, 2, 1'b0, 1'b0);

        // Steady state across the pointer wrap, all coefficients 1.
        pulseClear();
        for (int i = 0; i < N_TAPS; i++) writeCoef(i, 1, rej);
        for (int i = 0; i < 20; i++) begin
            feedAndCheck($sformatf("steady_%0d", i), 100,
                         100 * ((i + 1 < N_TAPS) ? i + 1 : N_TAPS), 1'b0, 1'b0);
        end

        // Flush mid-MAC: no result, ready next cycle, history gone.
        bus.in_valid = 1'b1;
        bus.x_in     = 16'sd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        pulseClear();
        checkOutput("flush_in_ready", bus.in_ready, 1);
        seen = 0;
        repeat (15) begin
            if (bus.y_valid) seen++;
            @(negedge clk);
        end
        checkOutput("flush_no_y_valid", seen, 0);
        checkOutput("flush_y_held", bus.y_out, 800);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in     = 16'sd9;
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("clear_drops_sample", bus.in_ready, 1);
        for (int i = 0; i < N_TAPS; i++) writeCoef(i, i + 1, rej);
        for (int i = 0; i < N_TAPS; i++) begin
            feedAndCheck($sformatf("post_flush_%0d", i), (i == 0) ? 1 : 0, i + 1, 1'b0, 1'b0);
        end

        // Saturation: all coef 32767, x = 32767 then x = -32768.
        pulseClear();
        for (int i = 0; i < N_TAPS; i++) writeCoef(i, 32767, rej);
        for (int i = 0; i < N_TAPS; i++) begin
            feedAndCheck($sformatf("sat_pos_%0d", i), 32767,
                         (i == 0) ? 64'sd1073676289 : (i == 1) ? 64'sd2147352578 : Y_MAX,
                         (i >= 2), 1'b0);
        end
        neg_y[0] = Y_MAX;          neg_sat[0] = 1'b1;
        neg_y[1] = Y_MAX;          neg_sat[1] = 1'b1;
        neg_y[2] = 64'sd2147254277; neg_sat[2] = 1'b0;
        neg_y[3] = -64'sd131068;   neg_sat[3] = 1'b0;
        neg_y[4] = Y_MIN;          neg_sat[4] = 1'b1;
        neg_y[5] = Y_MIN;          neg_sat[5] = 1'b1;
        neg_y[6] = Y_MIN;          neg_sat[6] = 1'b1;
        neg_y[7] = Y_MIN;          neg_sat[7] = 1'b1;
        for (int i = 0; i < N_TAPS; i++) begin
            feedAndCheck($sformatf("sat_neg_%0d", i), -32768, neg_y[i], neg_sat[i], 1'b0);
        end

        // Out-of-range coefficient address on the 6-tap instance.
        bus_small.coef_we    = 1'b1;
        bus_small.coef_addr  = 3'd6;
        bus_small.coef_wdata = 16'sd99;
        @(negedge clk);
        bus_small.coef_we = 1'b0;
        checkOutput("small_rej_addr6", bus_small.coef_rej, 1);
        @(negedge clk);
        checkOutput("small_rej_one_cycle", bus_small.coef_rej, 0);
        bus_small.coef_we   = 1'b1;
        bus_small.coef_addr = 3'd7;
        @(negedge clk);
        bus_small.coef_we = 1'b0;
        checkOutput("small_rej_addr7", bus_small.coef_rej, 1);
        bus_small.coef_we    = 1'b1;
        bus_small.coef_addr  = 3'd0;
        bus_small.coef_wdata = 16'sd3;
        @(negedge clk);
        bus_small.coef_we = 1'b0;
        checkOutput("small_accept_addr0", bus_small.coef_rej, 0);
        bus_small.in_valid = 1'b1;
        bus_small.x_in     = 16'sd2;
        @(negedge clk);
        bus_small.in_valid = 1'b0;
        lat = 0;
        while (!bus_small.y_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("small_latency", lat, N_SMALL + 1);
        checkOutput("small_y", bus_small.y_out, 6);

        // Asynchronous reset in the middle of a MAC.
        bus.in_valid = 1'b1;
        bus.x_in     = 16'sd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_in_ready", bus.in_ready, 1);
        checkOutput("async_rst_y_out", bus.y_out, 0);
        checkOutput("async_rst_sat", bus.sat, 0);
        checkOutput("async_rst_y_valid", bus.y_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        feedAndCheck("post_rst_coef_lost", 1234, 0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end
endmodule
